// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in / serial-out serializer.
package piso_pkg;

  // Default parallel word width and clocks per serial bit.
  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_DIV    = 4;

  // Controller states. The unused code 2'd3 is folded back to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Width of a counter that must count 0..n-1. It is never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bit_tick.sv
// Modulo-DIV bit timer. It produces a one-cycle tick on the last cycle of each bit period and
// flags the first cycle of each period.
module bit_tick
  import piso_pkg::*;
#(
  parameter int unsigned DIV = DEF_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic tick,
  output logic first
);

  localparam int unsigned     CntW    = cnt_width(DIV);
  localparam logic [CntW-1:0] LastCnt = CntW'(DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Next count. Clear has priority, and the count wraps after DIV enabled cycles.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LastCnt) ? '0 : cnt_q + CntW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick  = en && (cnt_q == LastCnt);
  assign first = en && (cnt_q == '0);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in / serial-out serializer. It accepts one word per valid/ready handshake and shifts
// the word out on d_o. Each bit is held for DIV clocks. A done pulse follows the last bit.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned DIV       = DEF_DIV,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic              d_o,
  output logic              bit_en_o,
  output logic              busy_o,
  output logic              done_o
);

  // The bit counter counts completed bits 0..DATA_W.
  localparam int unsigned        BitCntW = $clog2(DATA_W + 1);
  localparam logic [BitCntW-1:0] LastBit = BitCntW'(DATA_W - 1);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [BitCntW-1:0]  bit_cnt_q, bit_cnt_d;
  logic                handshake;
  logic                shifting;
  logic                tick;
  logic                first;

  assign handshake = valid_i && (state_q == ST_IDLE);
  assign shifting  = (state_q == ST_SHIFT);

  bit_tick #(
    .DIV (DIV)
  ) u_bit_tick (
    .clk   (clk_i),
    .rst_n (rst_i),
    .clear (handshake),
    .en    (shifting),
    .tick  (tick),
    .first (first)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Leave SHIFT when the last bit period ends.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (handshake) state_d = ST_SHIFT;
      ST_SHIFT: if (tick && (bit_cnt_q == LastBit)) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Next values for the shift register and the bit counter. A handshake loads both.
  // Each bit-period tick advances both.
  always_comb begin
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    if (handshake) begin
      shreg_d   = data_i;
      bit_cnt_d = '0;
    end else if (shifting && tick) begin
      if (MSB_FIRST) begin
        shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
      end else begin
        shreg_d = {1'b0, shreg_q[DATA_W-1:1]};
      end
      bit_cnt_d = bit_cnt_q + BitCntW'(1);
    end
  end

  // Shift register and bit counter registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      shreg_q   <= '0;
      bit_cnt_q <= '0;
    end else begin
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  // Outputs are decoded from the current state. d_o is the outgoing end of the shift register.
  always_comb begin
    ready_o  = 1'b0;
    busy_o   = 1'b0;
    d_o      = 1'b0;
    bit_en_o = 1'b0;
    done_o   = 1'b0;
    case (state_q)
      ST_IDLE: ready_o = 1'b1;
      ST_SHIFT: begin
        busy_o   = 1'b1;
        d_o      = MSB_FIRST ? shreg_q[DATA_W-1] : shreg_q[0];
        bit_en_o = first;
      end
      ST_DONE: done_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer. Three instances share one clock and one reset:
//   0: default parameters (DIV=4, MSB first)
//   1: DIV=4, LSB first
//   2: DIV=1, MSB first, with d_o driving a 4-stage flip-flop chain
module tb_piso_serializer;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] data   [3];
  logic          valid  [3];
  logic          ready  [3];
  logic          d      [3];
  logic          bit_en [3];
  logic          busy   [3];
  logic          done   [3];

  int  divs [3] = '{4, 4, 1};
  bit  msbs [3] = '{1'b1, 1'b0, 1'b1};

  // Reference model state: edges since the handshake, or -1 when idle.
  int            t [3];
  logic [DW-1:0] w [3];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [3:0] chain;
  logic       hist [$];

  always #5 clk = ~clk;

  piso_serializer #(.DATA_W(DW), .DIV(4), .MSB_FIRST(1'b1)) u_dut0 (
    .clk_i(clk), .rst_i(rst_n), .data_i(data[0]), .valid_i(valid[0]), .ready_o(ready[0]),
    .d_o(d[0]), .bit_en_o(bit_en[0]), .busy_o(busy[0]), .done_o(done[0]));

  piso_serializer #(.DATA_W(DW), .DIV(4), .MSB_FIRST(1'b0)) u_dut1 (
    .clk_i(clk), .rst_i(rst_n), .data_i(data[1]), .valid_i(valid[1]), .ready_o(ready[1]),
    .d_o(d[1]), .bit_en_o(bit_en[1]), .busy_o(busy[1]), .done_o(done[1]));

  piso_serializer #(.DATA_W(DW), .DIV(1), .MSB_FIRST(1'b1)) u_dut2 (
    .clk_i(clk), .rst_i(rst_n), .data_i(data[2]), .valid_i(valid[2]), .ready_o(ready[2]),
    .d_o(d[2]), .bit_en_o(bit_en[2]), .busy_o(busy[2]), .done_o(done[2]));

  // Downstream shift chain fed by the DIV=1 instance.
  always_ff @(posedge clk) chain <= {chain[2:0], d[2]};

  // Expected {ready, busy, d, bit_en, done} after an edge, from the bit-timing rules.
  function automatic logic [4:0] model_out(int tt, logic [DW-1:0] ww, int div, bit msb);
    int k;
    int idx;
    if (tt < 0) return 5'b10000;
    if (tt == DW * div) return 5'b00001;
    k   = tt / div;
    idx = msb ? (DW - 1 - k) : k;
    return {1'b0, 1'b1, ww[idx], ((tt % div) == 0), 1'b0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_idle();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset dut%0d {rdy,bsy,d,en,dn}", i),
            {27'd0, ready[i], busy[i], d[i], bit_en[i], done[i]}, 32'b10000);
    end
  endtask

  // One clock. This advances the model on the inputs held across the edge and then compares
  // every instance and the chain.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        t[i] = -1;
      end else if (t[i] < 0) begin
        if (valid[i]) begin
          t[i] = 0;
          w[i] = data[i];
        end
      end else begin
        t[i]++;
        if (t[i] > DW * divs[i]) t[i] = -1;
      end
      check($sformatf("dut%0d cyc%0d {rdy,bsy,d,en,dn}", i, cyc),
            {27'd0, ready[i], busy[i], d[i], bit_en[i], done[i]},
            {27'd0, model_out(t[i], w[i], divs[i], msbs[i])});
    end
    hist.push_back(d[2]);
    if (hist.size() == 5) begin
      check($sformatf("chain q cyc%0d", cyc), {31'd0, chain[3]}, {31'd0, hist[0]});
      void'(hist.pop_front());
    end
  endtask

  // Hand one word to an idle instance and record what it shows until it is ready again.
  task automatic run_word(input int i, input logic [DW-1:0] word, output logic [DW-1:0] bits,
                          output int pulses, output int done_edge, output int ready_edge);
    valid[i] = 1'b1;
    data[i]  = word;
    step();
    valid[i] = 1'b0;
    data[i]  = ~word;
    bits = '0;
    pulses = 0;
    done_edge = -1;
    ready_edge = -1;
    for (int e = 0; e <= DW * divs[i] + 1; e++) begin
      if (bit_en[i]) begin
        pulses++;
        bits = {bits[DW-2:0], d[i]};
      end
      if (done[i] && done_edge < 0) done_edge = e;
      if (ready[i] && ready_edge < 0) ready_edge = e;
      if (e < DW * divs[i] + 1) step();
    end
  endtask

  typedef struct {
    int            dut;
    logic [DW-1:0] word;
    logic [DW-1:0] bits;   // bits in the order they appear on d_o
    int            done_edge;
  } vec_t;

  vec_t          vecs [4];
  logic [DW-1:0] got_bits;
  int            got_pulses, got_done, got_ready;
  int            h0, h1;
  logic          pr;

  initial begin
    vecs[0] = '{0, 8'hA5, 8'b10100101, 32};
    vecs[1] = '{1, 8'h01, 8'b10000000, 32};
    vecs[2] = '{2, 8'h96, 8'b10010110, 8};
    vecs[3] = '{1, 8'hC4, 8'b00100011, 32};

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      valid[i] = 1'b0;
      data[i]  = '0;
      t[i]     = -1;
      w[i]     = '0;
    end
    #1;
    check_idle();
    step();
    step();
    rst_n = 1'b1;

    // Known words. The first word is handed over on the first edge after reset release.
    for (int v = 0; v < 4; v++) begin
      run_word(vecs[v].dut, vecs[v].word, got_bits, got_pulses, got_done, got_ready);
      check($sformatf("vec%0d bits", v), {24'd0, got_bits}, {24'd0, vecs[v].bits});
      check($sformatf("vec%0d bit_en pulses", v), got_pulses, DW);
      check($sformatf("vec%0d done edge", v), got_done, vecs[v].done_edge);
      check($sformatf("vec%0d ready edge", v), got_ready, vecs[v].done_edge + 1);
    end

    // valid held high. The second handshake must come 34 edges after the first one.
    valid[0] = 1'b1;
    data[0]  = 8'hFF;
    h0 = -1;
    h1 = -1;
    for (int n = 0; n < 100 && h1 < 0; n++) begin
      pr = ready[0];
      step();
      if (pr) begin
        if (h0 < 0) begin
          h0 = cyc;
          data[0] = 8'h00;
        end else begin
          h1 = cyc;
        end
      end
    end
    valid[0] = 1'b0;
    check("held-valid handshake spacing", h1 - h0, 34);
    repeat (40) step();

    // Reset in the middle of a word. The word is discarded and no done pulse follows.
    valid[0] = 1'b1;
    data[0]  = 8'hC3;
    step();
    valid[0] = 1'b0;
    repeat (9) step();
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) t[i] = -1;
    check_idle();
    repeat (3) step();
    rst_n = 1'b1;
    run_word(0, 8'h3C, got_bits, got_pulses, got_done, got_ready);
    check("post-reset word bits", {24'd0, got_bits}, 32'h3C);
    check("post-reset done edge", got_done, 32);

    // Random traffic on all instances with one reset pulse partway through.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 3; i++) begin
        valid[i] = ($urandom_range(0, 3) == 0);
        data[i]  = DW'($urandom);
      end
      if (n == 217) rst_n = 1'b0;
      if (n == 220) rst_n = 1'b1;
      step();
    end
    for (int i = 0; i < 3; i++) valid[i] = 1'b0;
    repeat (40) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
